serial_twos_comp_array: RTL and testbench

Parametrised, multi-channel bit-serial two's-complement unit. It accepts CH parallel LSB-first serial words of W bits and returns each word on a serial output one word later, as one of: passed through, negated, or absolute value. Mode is selectable per channel. It succeeds the single-channel serial complementer in the serial arithmetic datapath, adding word framing, a valid qualifier, per-channel modes and overflow detection.

---
 rtl/serial_cplx_pkg.sv | 15 +
 rtl/serial_neg_lane.sv | 76 +++++++
 rtl/serial_twos_comp_array.sv | 84 ++++++++
 tb/tb_serial_twos_comp_array.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cplx_pkg.sv
// Shared constants and helpers for the bit-serial complement datapath.
package serial_cplx_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_NEG  = 2'd1;
  localparam logic [1:0] MODE_ABS  = 2'd2;

  localparam int unsigned MAX_W = 64;

  // Most-negative two's-complement pattern (1 followed by w-1 zeros).
  function automatic logic [MAX_W-1:0] most_neg(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// One channel: captures an LSB-first word, then replays it passed or negated.
module serial_neg_lane
  import serial_cplx_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_beat,
  input  logic       i_load,
  input  logic       i_adv,
  input  logic       i_x,
  input  logic [1:0] i_mode,
  output logic       o_y,
  output logic       o_ovf
);

  logic [W-2:0] r_cap;
  logic [W-2:0] r_sh;
  logic         r_neg;
  logic         r_seen;
  logic         r_ovf;
  logic         r_y;
  logic [W-1:0] w_word;
  logic         w_neg;
  logic         w_bit;

  // Completed word as seen on the beat carrying its top bit.
  assign w_word = {i_x, r_cap};
  assign w_bit  = r_sh[0];

  always_comb begin
    w_neg = 1'b0;
    case (i_mode)
      MODE_NEG: w_neg = 1'b1;
      MODE_ABS: w_neg = i_x;
      default:  w_neg = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap <= '0;
    end else if (i_beat) begin
      r_cap <= w_word[W-1:1];
    end
  end

  // Bit 0 is always copied, so it goes straight out on the load edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh   <= '0;
      r_neg  <= 1'b0;
      r_seen <= 1'b0;
      r_ovf  <= 1'b0;
      r_y    <= 1'b0;
    end else if (i_load) begin
      r_sh   <= w_word[W-1:1];
      r_neg  <= w_neg;
      r_seen <= w_word[0];
      r_ovf  <= w_neg & (w_word == W'(most_neg(W)));
      r_y    <= w_word[0];
    end else if (i_adv) begin
      r_sh   <= r_sh >> 1;
      r_seen <= r_seen | w_bit;
      r_y    <= w_bit ^ (r_neg & r_seen);
    end else begin
      r_y    <= 1'b0;
      r_ovf  <= 1'b0;
    end
  end

  assign o_y   = r_y;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/serial_twos_comp_array.sv
// Multi-channel bit-serial pass/negate/abs unit with word framing and overflow flags.
module serial_twos_comp_array
  import serial_cplx_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CH = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic            sof,
  input  logic [CH-1:0]   x,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   y,
  output logic            out_valid,
  output logic            out_sof,
  output logic [CH-1:0]   ovf
);

  localparam int unsigned BW = $clog2(W);
  localparam logic [BW-1:0] LAST = BW'(W - 1);

  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] r_ocnt;
  logic          r_out_valid;
  logic          r_out_sof;
  logic [BW-1:0] w_idx;
  logic          w_load;
  logic          w_adv;

  // sof always restarts at bit 0, discarding any partial word.
  assign w_idx  = sof ? '0 : r_bcnt;
  assign w_load = in_valid & (w_idx == LAST);
  assign w_adv  = r_out_valid & (r_ocnt != LAST) & ~w_load;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt <= '0;
    end else if (in_valid) begin
      r_bcnt <= w_load ? '0 : w_idx + BW'(1);
    end
  end

  // Free-running output framing, restarted by each load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ocnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
    end else begin
      r_out_sof <= w_load;
      if (w_load) begin
        r_ocnt      <= '0;
        r_out_valid <= 1'b1;
      end else if (r_out_valid) begin
        if (r_ocnt == LAST) begin
          r_out_valid <= 1'b0;
        end else begin
          r_ocnt <= r_ocnt + BW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    serial_neg_lane #(
      .W(W)
    ) u_lane (
      .i_clk  (clock),
      .i_rst_n(reset_n),
      .i_beat (in_valid),
      .i_load (w_load),
      .i_adv  (w_adv),
      .i_x    (x[g]),
      .i_mode (mode[2*g +: 2]),
      .o_y    (y[g]),
      .o_ovf  (ovf[g])
    );
  end

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;

endmodule

// File: tb/tb_serial_twos_comp_array.sv
// Randomized self-checking bench for serial_twos_comp_array against a word-level model.
module tb_serial_twos_comp_array;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 2;

  logic            clock;
  logic            reset_n;
  logic            in_valid;
  logic            sof;
  logic [CH-1:0]   x;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   y;
  logic            out_valid;
  logic            out_sof;
  logic [CH-1:0]   ovf;

  serial_twos_comp_array #(.W(W), .CH(CH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .sof      (sof),
    .x        (x),
    .mode     (mode),
    .y        (y),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .ovf      (ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [CH*W-1:0] word;
    logic [CH-1:0]   ovf;
    int              start;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            cur;
  logic [CH*W-1:0] hist[$];
  logic [W-1:0]    m_cap[CH];
  int              m_bcnt;
  int              n_checks;
  int              n_errors;
  int              neg_cnt;
  int              k;
  int              vrun;
  int              max_vrun;
  bit              collecting;
  logic [CH*W-1:0] acc;
  logic [CH-1:0]   ovf_and;
  logic [CH-1:0]   ovf_or;
  logic [CH-1:0]   last_ovf_and;
  logic [CH-1:0]   last_ovf_or;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [CH*W-1:0] last_word(input int back);
    if (hist.size() > back) return hist[hist.size() - 1 - back];
    return '1;
  endfunction

  // Word-level reference: bits land at their index, result computed arithmetically.
  task automatic model_accept(input logic s, input logic [CH-1:0] xv, input logic [2*CH-1:0] m);
    int   idx;
    exp_t e;
    idx = s ? 0 : m_bcnt;
    for (int c = 0; c < CH; c++) m_cap[c][idx] = xv[c];
    if (idx == W - 1) begin
      for (int c = 0; c < CH; c++) begin
        logic [W-1:0] wd;
        logic [1:0]   md;
        bit           ng;
        wd = m_cap[c];
        md = m[2*c +: 2];
        ng = (md == 2'd1) || (md == 2'd2 && wd[W-1]);
        e.word[c*W +: W] = ng ? W'(0 - wd) : wd;
        e.ovf[c] = ng && (wd == (W'(1) << (W - 1)));
      end
      e.start = neg_cnt + 1;
      exp_q.push_back(e);
      m_bcnt = 0;
    end else begin
      m_bcnt = idx + 1;
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic [CH-1:0] xv, input logic [2*CH-1:0] m);
    @(negedge clock);
    in_valid = v;
    sof      = s;
    x        = xv;
    mode     = m;
    @(posedge clock);
    if (v && reset_n) model_accept(s, xv, m);
  endtask

  task automatic idle_beat();
    beat(1'b0, 1'($urandom), CH'($urandom), (2*CH)'($urandom));
  endtask

  // Mode is randomized on every beat except the one that completes the word.
  task automatic send_word(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [1:0] m0, input logic [1:0] m1,
                           input bit use_sof, input int gap_max);
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat ($urandom_range(0, gap_max)) idle_beat();
      beat(1'b1, (i == 0) && use_sof, {w1[i], w0[i]},
           (i == W - 1) ? {m1, m0} : (2*CH)'($urandom));
    end
  endtask

  task automatic partial(input int n, input bit first_sof);
    for (int i = 0; i < n; i++)
      beat(1'b1, (i == 0) && first_sof, CH'($urandom), (2*CH)'($urandom));
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clock);
    in_valid = 1'b0;
    sof      = 1'b0;
    while ((exp_q.size() != 0 || collecting) && n < 4 * W) begin
      @(posedge clock);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size() != 0 || collecting), 32'd0);
    repeat (2) @(posedge clock);
  endtask

  // Output monitor: frames words, checks idle levels, latency and per-cycle ovf.
  always @(negedge clock) begin
    neg_cnt++;
    if (!reset_n) begin
      collecting = 1'b0;
      vrun = 0;
    end else if (!out_valid) begin
      chk("idle_out", 32'({out_sof, ovf, y}), 32'd0);
      if (collecting) begin
        chk("word_cut", 32'(k), 32'(W));
        collecting = 1'b0;
      end
      vrun = 0;
    end else begin
      vrun++;
      if (vrun > max_vrun) max_vrun = vrun;
      if (out_sof) begin
        if (collecting) chk("word_cut", 32'(k), 32'(W));
        chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("latency", 32'(neg_cnt), 32'(cur.start));
          collecting = 1'b1;
          k = 0;
          ovf_and = '1;
          ovf_or  = '0;
        end else begin
          collecting = 1'b0;
        end
      end else begin
        chk("valid_in_word", 32'(collecting), 32'd1);
      end
      if (collecting) begin
        for (int c = 0; c < CH; c++) acc[c*W + k] = y[c];
        chk("ovf", 32'(ovf), 32'(cur.ovf));
        ovf_and = ovf_and & ovf;
        ovf_or  = ovf_or | ovf;
        k++;
        if (k == W) begin
          chk("word", 32'(acc), 32'(cur.word));
          hist.push_back(acc);
          last_ovf_and = ovf_and;
          last_ovf_or  = ovf_or;
          collecting = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    clock = 1'b0; reset_n = 1'b0; in_valid = 1'b0; sof = 1'b0; x = '0; mode = '0;
    n_checks = 0; n_errors = 0; neg_cnt = 0; m_bcnt = 0; max_vrun = 0; vrun = 0;
    collecting = 1'b0; k = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 32'({out_sof, out_valid, ovf, y}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // NEG 0x06 -> 0xFA
    send_word(8'h06, 8'h00, 2'd1, 2'd0, 1'b1, 0);
    drain();
    chk("s1_word", 32'(last_word(0)), 32'h00FA);
    chk("s1_ovf", 32'(last_ovf_or), 32'd0);

    // ABS back-to-back, continuous output
    max_vrun = 0;
    send_word(8'hF3, 8'h7F, 2'd2, 2'd2, 1'b1, 0);
    send_word(8'h25, 8'h81, 2'd2, 2'd2, 1'b0, 0);
    drain();
    chk("s2_word0", 32'(last_word(1)), 32'h7F0D);
    chk("s2_word1", 32'(last_word(0)), 32'h7F25);
    chk("s2_run", 32'(max_vrun), 32'd16);

    // Most-negative and zero under NEG
    send_word(8'h80, 8'h00, 2'd1, 2'd1, 1'b1, 0);
    drain();
    chk("s3_word", 32'(last_word(0)), 32'h0080);
    chk("s3_ovf", 32'({last_ovf_or, last_ovf_and}), 32'h5);
    send_word(8'h00, 8'h00, 2'd1, 2'd0, 1'b1, 0);
    drain();
    chk("s3_zero", 32'(last_word(0)), 32'h0000);
    chk("s3_zero_ovf", 32'(last_ovf_or), 32'd0);

    // Gapped input, reserved-safe modes
    send_word(8'hA5, 8'h01, 2'd0, 2'd1, 1'b1, 1);
    drain();
    chk("s4_word", 32'(last_word(0)), 32'hFFA5);

    // Abort at bit 4
    n = hist.size();
    partial(4, 1'b1);
    send_word(8'h3C, 8'h00, 2'd1, 2'd0, 1'b1, 0);
    drain();
    chk("s5_count", 32'(hist.size()), 32'(n + 1));
    chk("s5_word", 32'(last_word(0)), 32'h00C4);

    // Reset during output bit 3
    send_word(8'h5A, 8'h33, 2'd0, 2'd0, 1'b1, 0);
    repeat (3) idle_beat();
    #2;
    chk("s6_pre_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("s6_y", 32'(y), 32'd0);
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_sof", 32'(out_sof), 32'd0);
    chk("s6_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    m_bcnt = 0;
    n = hist.size();
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2 * W) idle_beat();
    chk("s6_quiet", 32'(hist.size()), 32'(n));
    send_word(8'h3C, 8'h02, 2'd1, 2'd2, 1'b0, 0);
    drain();
    chk("s6_count", 32'(hist.size()), 32'(n + 1));
    chk("s6_word", 32'(last_word(0)), 32'h02C4);

    // Random traffic with gaps, aborts and mixed framing
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        partial($urandom_range(1, W - 1), 1'($urandom));
        send_word(W'($urandom), W'($urandom), 2'($urandom), 2'($urandom), 1'b1,
                  $urandom_range(0, 2));
      end else begin
        send_word(W'($urandom), W'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  $urandom_range(0, 2));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
